// File: rtl/sb_drain_ctrl.sv
// Store-buffer drain: moves the head entry to the dcache write port, arbitrating against loads.
// Latency go->wr_valid 1 cycle, earliest pop 2; wr_* held until wr_ready, NACKs re-issued after backoff.
module sb_drain_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8,
  parameter int RETRY_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                sb_valid_i,
  input  logic [ADDR_W-1:0]   sb_addr_i,
  input  logic [DATA_W-1:0]   sb_data_i,
  input  logic [DATA_W/8-1:0] sb_strb_i,
  input  logic                sb_full_i,
  output logic                sb_pop_o,
  input  logic                ld_req_i,
  output logic                ld_gnt_o,
  output logic                wr_valid_o,
  input  logic                wr_ready_i,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  input  logic                wr_resp_valid_i,
  input  logic                wr_resp_retry_i,
  input  logic                fence_req_i,
  output logic                fence_ack_o
);
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int BC_W = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, BACKOFF} state_t;

  state_t          state;
  logic [SC_W-1:0] starve_cnt;
  logic [BC_W-1:0] backoff_cnt;
  logic            fence_pend;
  logic            flushed;
  logic            starved;
  logic            go;

  assign starved  = (starve_cnt == SC_W'(STARVE_MAX));
  assign go       = (state == IDLE) & sb_valid_i & !flush_i &
                    (!ld_req_i | starved | sb_full_i | fence_pend);
  assign ld_gnt_o = ld_req_i & (state == IDLE) & !go;
  // A flush seen at any point of the wait turns the eventual response into a no-op.
  assign sb_pop_o = (state == WAIT_RESP) & wr_resp_valid_i & !wr_resp_retry_i &
                    !flushed & !flush_i & !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      backoff_cnt <= '0;
      fence_pend  <= 1'b0;
      fence_ack_o <= 1'b0;
      flushed     <= 1'b0;
      wr_valid_o  <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      wr_strb_o   <= '0;
    end else begin
      fence_ack_o <= 1'b0;
      if (flush_i) begin
        fence_pend <= 1'b0;
      end else if (fence_pend && state == IDLE && !sb_valid_i) begin
        fence_pend  <= 1'b0;
        fence_ack_o <= 1'b1;
      end else if (fence_req_i && !fence_pend && !fence_ack_o) begin
        fence_pend <= 1'b1;
      end

      if (flush_i || go) begin
        starve_cnt <= '0;
      end else if (state == IDLE && sb_valid_i && ld_req_i && !starved) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end

      case (state)
        IDLE: begin
          if (go) begin
            state      <= REQ;
            wr_valid_o <= 1'b1;
            wr_addr_o  <= sb_addr_i;
            wr_data_o  <= sb_data_i;
            wr_strb_o  <= sb_strb_i;
          end
        end
        REQ: begin
          if (flush_i) begin
            state      <= IDLE;
            wr_valid_o <= 1'b0;
          end else if (wr_ready_i) begin
            state      <= WAIT_RESP;
            wr_valid_o <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (flush_i) flushed <= 1'b1;
          if (wr_resp_valid_i) begin
            if (wr_resp_retry_i && !flushed && !flush_i) begin
              state       <= BACKOFF;
              backoff_cnt <= BC_W'(RETRY_WAIT - 1);
            end else begin
              state   <= IDLE;
              flushed <= 1'b0;
            end
          end
        end
        BACKOFF: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (backoff_cnt == '0) begin
            state      <= REQ;
            wr_valid_o <= 1'b1;
          end else begin
            backoff_cnt <= backoff_cnt - BC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_drain_ctrl.sv
// Bench for sb_drain_ctrl: arbitration vectors, directed drain/retry/fence/flush/reset sequences,
// and a randomized run checked every cycle against a transaction-level model.
module tb_sb_drain_ctrl;
  localparam int SMAX = 8;
  localparam int RW   = 4;

  logic clk = 1'b0;
  logic rst, flush, sb_valid, sb_full, sb_pop, ld_req, ld_gnt;
  logic wr_valid, wr_ready, wr_resp_valid, wr_resp_retry, fence_req, fence_ack;
  logic [31:0] sb_addr, sb_data, wr_addr, wr_data;
  logic [3:0]  sb_strb, wr_strb;

  always #5 clk = ~clk;

  sb_drain_ctrl #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .RETRY_WAIT(RW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .sb_valid_i(sb_valid), .sb_addr_i(sb_addr), .sb_data_i(sb_data), .sb_strb_i(sb_strb),
    .sb_full_i(sb_full), .sb_pop_o(sb_pop), .ld_req_i(ld_req), .ld_gnt_o(ld_gnt),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_strb_o(wr_strb), .wr_resp_valid_i(wr_resp_valid), .wr_resp_retry_i(wr_resp_retry),
    .fence_req_i(fence_req), .fence_ack_o(fence_ack)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  typedef struct {
    bit v, l, f, fl;
    bit eg, ev;
  } vec_t;

  ent_t sbq[$];
  bit   full_force;
  int   checks = 0;
  int   errors = 0;

  // transaction-level model: one entry in flight, where it sits, and fence/starvation bookkeeping
  bit   m_have, m_bus, m_doom, m_fwait, m_ack;
  int   m_back, m_loss;
  ent_t m_txn;

  logic s_valid, s_pop, s_gnt, s_ack;
  logic [31:0] s_addr, s_data;
  logic [3:0]  s_strb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ent_t e;
    e.a = a; e.d = d; e.s = s;
    sbq.push_back(e);
  endtask

  task automatic drive_sb();
    if (sbq.size() > 0) begin
      sb_valid = 1'b1;
      sb_addr  = sbq[0].a;
      sb_data  = sbq[0].d;
      sb_strb  = sbq[0].s;
    end else begin
      sb_valid = 1'b0;
      sb_addr  = '0;
      sb_data  = '0;
      sb_strb  = '0;
    end
    sb_full = (sbq.size() >= 4) || full_force;
  endtask

  function automatic bit m_waiting();
    return m_have && !m_bus && m_back == 0;
  endfunction

  task automatic model_step();
    bit win, gnt, pop, nack;
    ent_t head;
    head = (sbq.size() > 0) ? sbq[0] : '0;
    win  = !m_have && sb_valid && !flush &&
           (!ld_req || m_loss == SMAX || sb_full || m_fwait);
    gnt  = ld_req && !m_have && !win;
    pop  = m_waiting() && wr_resp_valid && !wr_resp_retry && !m_doom && !flush && !rst;

    chk("wr_valid", {63'd0, wr_valid}, {63'd0, m_bus});
    if (m_bus) begin
      chk("wr_addr", {32'd0, wr_addr}, {32'd0, m_txn.a});
      chk("wr_data", {32'd0, wr_data}, {32'd0, m_txn.d});
      chk("wr_strb", {60'd0, wr_strb}, {60'd0, m_txn.s});
    end
    chk("sb_pop", {63'd0, sb_pop}, {63'd0, pop});
    chk("ld_gnt", {63'd0, ld_gnt}, {63'd0, gnt});
    chk("fence_ack", {63'd0, fence_ack}, {63'd0, m_ack});

    s_valid = wr_valid; s_pop = sb_pop; s_gnt = ld_gnt; s_ack = fence_ack;
    s_addr = wr_addr; s_data = wr_data; s_strb = wr_strb;

    if (rst) begin
      m_have = 0; m_bus = 0; m_doom = 0; m_fwait = 0; m_ack = 0;
      m_back = 0; m_loss = 0;
    end else begin
      nack = m_fwait && !m_have && !sb_valid && !flush;
      if (flush || nack) m_fwait = 0;
      else if (fence_req && !m_fwait && !m_ack) m_fwait = 1;
      m_ack = nack;

      if (flush || win) m_loss = 0;
      else if (!m_have && sb_valid && ld_req && m_loss < SMAX) m_loss++;

      if (!m_have) begin
        if (win) begin m_have = 1; m_bus = 1; m_txn = head; end
      end else if (m_bus) begin
        if (flush) begin m_have = 0; m_bus = 0; end
        else if (wr_ready) m_bus = 0;
      end else if (m_back > 0) begin
        if (flush) begin m_have = 0; m_back = 0; end
        else begin
          m_back--;
          if (m_back == 0) m_bus = 1;
        end
      end else begin
        if (flush) m_doom = 1;
        if (wr_resp_valid) begin
          if (wr_resp_retry && !m_doom) m_back = RW;
          else begin m_have = 0; m_doom = 0; end
        end
      end
    end

    if (rst || flush) sbq.delete();
    else if (pop) void'(sbq.pop_front());
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    drive_sb();
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; ld_req = 0; wr_ready = 0; wr_resp_valid = 0; wr_resp_retry = 0;
    fence_req = 0; full_force = 0;
    sbq.delete();
    drive_sb();
    tick();
    tick();
    rst = 0;
  endtask

  vec_t vt[8];
  int   cnt, pops, acks, gnt_bad, qn;
  ent_t e;

  initial begin
    rst = 1; flush = 0; ld_req = 0; wr_ready = 0; wr_resp_valid = 0; wr_resp_retry = 0;
    fence_req = 0; full_force = 0;
    m_have = 0; m_bus = 0; m_doom = 0; m_fwait = 0; m_ack = 0; m_back = 0; m_loss = 0;
    m_txn = '0;
    drive_sb();

    // reset state
    do_reset();
    chk("rst_wr_valid", {63'd0, s_valid}, 64'd0);
    chk("rst_pop", {63'd0, s_pop}, 64'd0);
    chk("rst_ack", {63'd0, s_ack}, 64'd0);
    chk("rst_addr", {32'd0, s_addr}, 64'd0);
    chk("rst_data", {32'd0, s_data}, 64'd0);
    chk("rst_strb", {60'd0, s_strb}, 64'd0);

    // arbitration from a fresh IDLE: {sb_valid, ld_req, sb_full, flush} -> {ld_gnt, wr_valid next}
    vt[0] = '{v:0, l:0, f:0, fl:0, eg:0, ev:0};
    vt[1] = '{v:0, l:1, f:0, fl:0, eg:1, ev:0};
    vt[2] = '{v:1, l:0, f:0, fl:0, eg:0, ev:1};
    vt[3] = '{v:1, l:1, f:0, fl:0, eg:1, ev:0};
    vt[4] = '{v:1, l:1, f:1, fl:0, eg:0, ev:1};
    vt[5] = '{v:1, l:0, f:0, fl:1, eg:0, ev:0};
    vt[6] = '{v:1, l:1, f:0, fl:1, eg:1, ev:0};
    vt[7] = '{v:0, l:1, f:1, fl:0, eg:1, ev:0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (vt[i].v) push(32'h100 + i, 32'hA000 + i, 4'hF);
      full_force = vt[i].f; ld_req = vt[i].l; flush = vt[i].fl;
      drive_sb();
      tick();
      chk($sformatf("vec%0d_gnt", i), {63'd0, s_gnt}, {63'd0, vt[i].eg});
      full_force = 0; ld_req = 0; flush = 0;
      drive_sb();
      tick();
      chk($sformatf("vec%0d_wr_valid", i), {63'd0, s_valid}, {63'd0, vt[i].ev});
    end

    // single drain, minimum latency
    do_reset();
    push(32'h1000, 32'hDEADBEEF, 4'hF);
    wr_ready = 1; drive_sb();
    tick();
    chk("t1_c0_valid", {63'd0, s_valid}, 64'd0);
    chk("t1_c0_pop", {63'd0, s_pop}, 64'd0);
    tick();
    chk("t1_c1_valid", {63'd0, s_valid}, 64'd1);
    chk("t1_c1_addr", {32'd0, s_addr}, 64'h1000);
    chk("t1_c1_data", {32'd0, s_data}, 64'hDEADBEEF);
    chk("t1_c1_strb", {60'd0, s_strb}, 64'hF);
    chk("t1_c1_pop", {63'd0, s_pop}, 64'd0);
    wr_resp_valid = 1;
    tick();
    chk("t1_c2_pop", {63'd0, s_pop}, 64'd1);
    wr_resp_valid = 0;
    tick();
    chk("t1_c3_pop", {63'd0, s_pop}, 64'd0);
    chk("t1_c3_valid", {63'd0, s_valid}, 64'd0);

    // starvation bound
    do_reset();
    push(32'h2000, 32'h0BADF00D, 4'h5);
    ld_req = 1; wr_ready = 1; drive_sb();
    cnt = 0;
    tick();
    while (s_gnt && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("t2_gnt_cycles", 64'(cnt), 64'(SMAX));
    chk("t2_valid_at_win", {63'd0, s_valid}, 64'd0);
    tick();
    chk("t2_valid_after", {63'd0, s_valid}, 64'd1);
    ld_req = 0; wr_resp_valid = 1;
    tick();
    chk("t2_pop", {63'd0, s_pop}, 64'd1);
    wr_resp_valid = 0;

    // NACK, backoff and re-issue of the same latched entry
    do_reset();
    push(32'h3000, 32'h12345678, 4'h3);
    wr_ready = 1; drive_sb();
    tick();
    tick();
    wr_resp_valid = 1; wr_resp_retry = 1;
    tick();
    chk("t3_retry_pop", {63'd0, s_pop}, 64'd0);
    wr_resp_valid = 0; wr_resp_retry = 0;
    cnt = 0;
    tick();
    while (!s_valid && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("t3_backoff_cycles", 64'(cnt), 64'(RW));
    chk("t3_reissue_addr", {32'd0, s_addr}, 64'h3000);
    chk("t3_reissue_data", {32'd0, s_data}, 64'h12345678);
    chk("t3_reissue_strb", {60'd0, s_strb}, 64'h3);
    wr_resp_valid = 1;
    tick();
    chk("t3_pop_ok", {63'd0, s_pop}, 64'd1);
    wr_resp_valid = 0;

    // fence with three entries and a greedy load pipe
    do_reset();
    push(32'h10, 32'h1, 4'h1); push(32'h20, 32'h2, 4'h2); push(32'h30, 32'h3, 4'h4);
    wr_ready = 1; fence_req = 1; drive_sb();
    pops = 0; acks = 0; gnt_bad = 0;
    for (int c = 0; c < 60 && acks == 0; c++) begin
      wr_resp_valid = m_waiting();
      qn = sbq.size();
      tick();
      if (qn > 0 && s_gnt) gnt_bad++;
      if (s_pop) pops++;
      if (s_ack) begin
        acks++;
        chk("t4_pops_before_ack", 64'(pops), 64'd3);
      end
      ld_req = 1;
    end
    chk("t4_ack_seen", 64'(acks), 64'd1);
    chk("t4_gnt_blocked", 64'(gnt_bad), 64'd0);
    fence_req = 0; ld_req = 0; wr_resp_valid = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (s_ack) acks++;
    end
    chk("t4_single_ack", 64'(acks), 64'd1);

    // flush while waiting for the response
    do_reset();
    push(32'h4000, 32'hCAFEF00D, 4'hC);
    wr_ready = 1; fence_req = 1; drive_sb();
    tick();
    tick();
    flush = 1; fence_req = 0;
    acks = 0;
    tick();
    if (s_ack) acks++;
    flush = 0;
    tick();
    if (s_ack) acks++;
    wr_resp_valid = 1;
    tick();
    if (s_ack) acks++;
    chk("t5_no_pop", {63'd0, s_pop}, 64'd0);
    wr_resp_valid = 0; ld_req = 1;
    tick();
    if (s_ack) acks++;
    chk("t5_idle_gnt", {63'd0, s_gnt}, 64'd1);
    chk("t5_idle_valid", {63'd0, s_valid}, 64'd0);
    ld_req = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (s_ack) acks++;
    end
    chk("t5_no_ack", 64'(acks), 64'd0);

    // reset while a request is stalled on wr_ready
    do_reset();
    push(32'h5000, 32'h55AA55AA, 4'hA);
    wr_ready = 0; drive_sb();
    tick();
    tick();
    chk("t6_valid_before", {63'd0, s_valid}, 64'd1);
    rst = 1; ld_req = 1;
    tick();
    chk("t6_rst_pop", {63'd0, s_pop}, 64'd0);
    rst = 0;
    tick();
    chk("t6_valid_after", {63'd0, s_valid}, 64'd0);
    chk("t6_gnt_follow1", {63'd0, s_gnt}, 64'd1);
    ld_req = 0;
    tick();
    chk("t6_gnt_follow0", {63'd0, s_gnt}, 64'd0);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (sbq.size() < 6 && $urandom_range(99) < 35) begin
        e.a = $urandom; e.d = $urandom; e.s = 4'($urandom);
        sbq.push_back(e);
      end
      ld_req        = ($urandom_range(99) < 50);
      wr_ready      = ($urandom_range(99) < 60);
      wr_resp_valid = m_waiting() && ($urandom_range(99) < 50);
      wr_resp_retry = ($urandom_range(99) < 30);
      flush         = ($urandom_range(99) < 2);
      rst           = ($urandom_range(999) < 4);
      if (!fence_req && $urandom_range(99) < 4) fence_req = 1;
      drive_sb();
      tick();
      if (s_ack) fence_req = 0;
    end
    rst = 0; flush = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
